// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches sysid words 0 and 1 after reset or on start,
// compares them with build-time values and reports pass/fail. SYSID_BOOT_CHECKER_IRQ_EN adds a fail irq.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1435139285,
    parameter int unsigned READ_LATENCY       = 0,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned START_DELAY        = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        id_ok,
    output logic        ts_ok,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [2:0] {
        DELAY,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_e;

    localparam logic [15:0] DELAY_LAST = 16'(START_DELAY - 1);
    localparam logic [3:0]  PHASE_LAST = 4'(READ_LATENCY + 1);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRIES);

    state_e      state_q;
    logic [15:0] delay_cnt_q;
    logic [3:0]  phase_cnt_q;
    logic        address_q;
    logic        read_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        fail_q;
    logic        id_ok_q;
    logic        ts_ok_q;
    logic [31:0] id_value_q;
    logic [31:0] ts_value_q;
    logic [3:0]  retry_q;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic        irq_q;
`endif

    logic id_ok_d;
    logic ts_ok_d;

    assign id_ok_d = (id_value_q == EXPECTED_ID);
    assign ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);

    // Each read word takes one address set-up cycle with read low, then
    // READ_LATENCY+1 cycles with read high; data is taken on the last of them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DELAY;
            delay_cnt_q <= '0;
            phase_cnt_q <= '0;
            address_q   <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            id_ok_q     <= 1'b0;
            ts_ok_q     <= 1'b0;
            id_value_q  <= '0;
            ts_value_q  <= '0;
            retry_q     <= '0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
            irq_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                DELAY: begin
                    if (delay_cnt_q == DELAY_LAST) begin
                        delay_cnt_q <= '0;
                        phase_cnt_q <= '0;
                        address_q   <= 1'b0;
                        state_q     <= RD_ID;
                    end else begin
                        delay_cnt_q <= delay_cnt_q + 16'd1;
                    end
                end

                RD_ID, RD_TS: begin
                    if (phase_cnt_q == PHASE_LAST) begin
                        read_q      <= 1'b0;
                        phase_cnt_q <= '0;
                        if (state_q == RD_ID) begin
                            id_value_q <= sysid_readdata;
                            address_q  <= 1'b1;
                            state_q    <= RD_TS;
                        end else begin
                            ts_value_q <= sysid_readdata;
                            state_q    <= CHECK;
                        end
                    end else begin
                        read_q      <= 1'b1;
                        phase_cnt_q <= phase_cnt_q + 4'd1;
                    end
                end

                CHECK: begin
                    id_ok_q <= id_ok_d;
                    ts_ok_q <= ts_ok_d;
                    if (id_ok_d && ts_ok_d) begin
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_q     <= retry_q + 4'd1;
                        address_q   <= 1'b0;
                        phase_cnt_q <= '0;
                        state_q     <= RD_ID;
                    end else begin
                        fail_q  <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
                        irq_q   <= 1'b1;
`endif
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    // A re-run skips DELAY; the slave is assumed alive by now.
                    if (start) begin
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        id_ok_q     <= 1'b0;
                        ts_ok_q     <= 1'b0;
                        retry_q     <= '0;
                        busy_q      <= 1'b1;
                        address_q   <= 1'b0;
                        phase_cnt_q <= '0;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
                        irq_q       <= 1'b0;
`endif
                        state_q     <= RD_ID;
                    end
                end

                default: begin
                    state_q <= DELAY;
                end
            endcase
        end
    end

    assign sysid_address = address_q;
    assign sysid_read    = read_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign id_value      = id_value_q;
    assign ts_value      = ts_value_q;
    assign retry_count   = retry_q;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    assign irq           = irq_q;
`endif

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: a default instance (combinational slave)
// and a READ_LATENCY=2 instance (registered slave).
module tb_sysid_boot_checker;

    localparam logic [31:0] GOOD_TS = 32'h558A7CD5;
    localparam logic [31:0] BAD_TS  = 32'h12345678;
    localparam logic [31:0] B_ID    = 32'hCAFE0001;
    localparam logic [31:0] FILLER  = 32'hDEADBEEF;

    typedef struct {
        int          edgeNum;
        logic        pass;
        logic        fail;
        logic        idOk;
        logic        tsOk;
        logic [31:0] idValue;
        logic [31:0] tsValue;
        logic [3:0]  retries;
        logic        irq;
    } expect_t;

    logic clock = 1'b0;
    int   cycle = 0;
    int   testsRun = 0;
    int   failCount = 0;

    logic        rstA_n, startA, addrA, readA, busyA, doneA, passA, failA, idOkA, tsOkA;
    logic [31:0] readdataA, idValA, tsValA;
    logic [3:0]  retryA;
    logic        rstB_n, startB, addrB, readB, busyB, doneB, passB, failB, idOkB, tsOkB;
    logic [31:0] readdataB, idValB, tsValB;
    logic [3:0]  retryB;
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
    logic        irqA, irqB;
`endif

    int modeA = 0;
    int tsReadsA = 0;
    int releaseEdgeA = 0;
    int releaseEdgeB = 0;
    int idReadCyclesB = 0;
    int tsReadCyclesB = 0;
    logic [31:0] pipe1B, pipe2B;
    logic doneSeenA = 1'b0;
    logic doneSeenB = 1'b0;
    expect_t expQA[$];
    expect_t expQB[$];

    sysid_boot_checker dutA (
        .clock(clock), .reset_n(rstA_n), .start(startA),
        .sysid_address(addrA), .sysid_read(readA), .sysid_readdata(readdataA),
        .busy(busyA), .done(doneA), .pass(passA), .fail(failA),
        .id_ok(idOkA), .ts_ok(tsOkA), .id_value(idValA), .ts_value(tsValA),
        .retry_count(retryA)
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        , .irq(irqA)
`endif
    );

    sysid_boot_checker #(.EXPECTED_ID(B_ID), .READ_LATENCY(2)) dutB (
        .clock(clock), .reset_n(rstB_n), .start(startB),
        .sysid_address(addrB), .sysid_read(readB), .sysid_readdata(readdataB),
        .busy(busyB), .done(doneB), .pass(passB), .fail(failB),
        .id_ok(idOkB), .ts_ok(tsOkB), .id_value(idValB), .ts_value(tsValB),
        .retry_count(retryB)
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        , .irq(irqB)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    // Slave A: combinational; mode 1 always returns a bad timestamp, mode 2 only on the first read.
    always_comb begin
        readdataA = 32'h0;
        if (addrA)
            readdataA = (modeA == 1 || (modeA == 2 && tsReadsA == 0)) ? BAD_TS : GOOD_TS;
    end

    always @(posedge clock) begin
        if (!rstA_n) tsReadsA <= 0;
        else if (readA && addrA) tsReadsA <= tsReadsA + 1;
    end

    // Slave B: two-stage registered pipeline; data only flows while read is high.
    always @(posedge clock) begin
        pipe1B <= readB ? (addrB ? GOOD_TS : B_ID) : FILLER;
        pipe2B <= pipe1B;
        if (!rstB_n) begin
            idReadCyclesB <= 0;
            tsReadCyclesB <= 0;
        end else if (readB) begin
            if (addrB) tsReadCyclesB <= tsReadCyclesB + 1;
            else       idReadCyclesB <= idReadCyclesB + 1;
        end
    end
    assign readdataB = pipe2B;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpect(input bit toB, input int edgeNum, input logic p, input logic f,
                              input logic io, input logic to, input logic [31:0] iv,
                              input logic [31:0] tv, input logic [3:0] r, input logic irqExp);
        expect_t e;
        e.edgeNum = edgeNum; e.pass = p; e.fail = f; e.idOk = io; e.tsOk = to;
        e.idValue = iv; e.tsValue = tv; e.retries = r; e.irq = irqExp;
        if (toB) expQB.push_back(e);
        else     expQA.push_back(e);
    endtask

    // Monitor A: scores every rising edge of done against the head of the queue.
    always @(posedge clock) begin
        expect_t e;
        #1;
        if (doneA && !doneSeenA) begin
            if (expQA.size() == 0) begin
                testsRun++; failCount++;
                $display("[TB] FAIL A.unexpectedDone: got done=1 at edge %0d, expected none", cycle - releaseEdgeA);
            end else begin
                e = expQA.pop_front();
                checkOutput("A.doneEdge", 32'(cycle - releaseEdgeA), 32'(e.edgeNum));
                checkOutput("A.pass",     32'(passA),  32'(e.pass));
                checkOutput("A.fail",     32'(failA),  32'(e.fail));
                checkOutput("A.idOk",     32'(idOkA),  32'(e.idOk));
                checkOutput("A.tsOk",     32'(tsOkA),  32'(e.tsOk));
                checkOutput("A.idValue",  idValA,      e.idValue);
                checkOutput("A.tsValue",  tsValA,      e.tsValue);
                checkOutput("A.retries",  32'(retryA), 32'(e.retries));
                checkOutput("A.busy",     32'(busyA),  32'd0);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
                checkOutput("A.irq",      32'(irqA),   32'(e.irq));
`endif
            end
        end
        doneSeenA = doneA;
    end

    always @(posedge clock) begin
        expect_t e;
        #1;
        if (doneB && !doneSeenB) begin
            if (expQB.size() == 0) begin
                testsRun++; failCount++;
                $display("[TB] FAIL B.unexpectedDone: got done=1 at edge %0d, expected none", cycle - releaseEdgeB);
            end else begin
                e = expQB.pop_front();
                checkOutput("B.doneEdge", 32'(cycle - releaseEdgeB), 32'(e.edgeNum));
                checkOutput("B.pass",     32'(passB),  32'(e.pass));
                checkOutput("B.fail",     32'(failB),  32'(e.fail));
                checkOutput("B.idValue",  idValB,      e.idValue);
                checkOutput("B.tsValue",  tsValB,      e.tsValue);
                checkOutput("B.retries",  32'(retryB), 32'(e.retries));
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
                checkOutput("B.irq",      32'(irqB),   32'(e.irq));
`endif
            end
        end
        doneSeenB = doneB;
    end

    task automatic checkResetStateA();
        checkOutput("A.rst.busy",    32'(busyA),  32'd1);
        checkOutput("A.rst.done",    32'(doneA),  32'd0);
        checkOutput("A.rst.pass",    32'(passA),  32'd0);
        checkOutput("A.rst.fail",    32'(failA),  32'd0);
        checkOutput("A.rst.read",    32'(readA),  32'd0);
        checkOutput("A.rst.addr",    32'(addrA),  32'd0);
        checkOutput("A.rst.idOk",    32'(idOkA),  32'd0);
        checkOutput("A.rst.tsOk",    32'(tsOkA),  32'd0);
        checkOutput("A.rst.tsValue", tsValA,      32'd0);
        checkOutput("A.rst.retries", 32'(retryA), 32'd0);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        checkOutput("A.rst.irq",     32'(irqA),   32'd0);
`endif
    endtask

    task automatic applyStimulus(input int mode);
        modeA = mode;
        @(negedge clock);
        rstA_n = 1'b0;
        #1;
        checkResetStateA();
        repeat (2) @(negedge clock);
        rstA_n = 1'b1;
        releaseEdgeA = cycle;
    endtask

    task automatic waitDone(input bit onB, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = onB ? doneB : doneA;
        end
        if (!seen) begin
            testsRun++; failCount++;
            $display("[TB] FAIL %s: got no done within 100 cycles, expected done", name);
        end
    endtask

    task automatic waitTsPhaseA(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clock);
            seen = addrA && busyA;
        end
        if (!seen) begin
            testsRun++; failCount++;
            $display("[TB] FAIL %s: got no RD_TS within 60 cycles, expected address=1", name);
        end
    endtask

    // Pulse start in DONE; the rerun is expected to pass 5 edges after the start edge.
    task automatic pulseStartA(input string name);
        int startEdge;
        @(negedge clock);
        startA = 1'b1;
        startEdge = cycle - releaseEdgeA + 1;
        pushExpect(1'b0, startEdge + 5, 1, 0, 1, 1, 32'h0, GOOD_TS, 4'd0, 1'b0);
        @(posedge clock);
        #1;
        startA = 1'b0;
        checkOutput({name, ".done"},    32'(doneA),  32'd0);
        checkOutput({name, ".pass"},    32'(passA),  32'd0);
        checkOutput({name, ".fail"},    32'(failA),  32'd0);
        checkOutput({name, ".busy"},    32'(busyA),  32'd1);
        checkOutput({name, ".idOk"},    32'(idOkA),  32'd0);
        checkOutput({name, ".retries"}, 32'(retryA), 32'd0);
`ifdef SYSID_BOOT_CHECKER_IRQ_EN
        checkOutput({name, ".irq"},     32'(irqA),   32'd0);
`endif
        waitDone(1'b0, {name, ".wait"});
    endtask

    initial begin
        rstA_n = 1'b0; startA = 1'b0;
        rstB_n = 1'b0; startB = 1'b0;

        applyStimulus(0);
        pushExpect(1'b0, 21, 1, 0, 1, 1, 32'h0, GOOD_TS, 4'd0, 1'b0);
        waitDone(1'b0, "A.default");

        applyStimulus(1);
        pushExpect(1'b0, 36, 0, 1, 1, 0, 32'h0, BAD_TS, 4'd3, 1'b1);
        waitDone(1'b0, "A.alwaysBad");
        modeA = 0;
        pulseStartA("A.startAfterFail");

        applyStimulus(2);
        pushExpect(1'b0, 26, 1, 0, 1, 1, 32'h0, GOOD_TS, 4'd1, 1'b0);
        waitDone(1'b0, "A.firstBad");
        pulseStartA("A.startAfterRetry");

        applyStimulus(0);
        pushExpect(1'b0, 21, 1, 0, 1, 1, 32'h0, GOOD_TS, 4'd0, 1'b0);
        waitTsPhaseA("A.startInTs.find");
        startA = 1'b1;
        @(negedge clock);
        startA = 1'b0;
        waitDone(1'b0, "A.startInTs");
        repeat (4) @(negedge clock);
        checkOutput("A.startInTs.holdDone", 32'(doneA), 32'd1);
        checkOutput("A.startInTs.holdBusy", 32'(busyA), 32'd0);

        applyStimulus(0);
        waitTsPhaseA("A.midReset.find");
        rstA_n = 1'b0;
        #1;
        checkResetStateA();
        checkOutput("A.midReset.idValue", idValA, 32'd0);
        repeat (3) @(negedge clock);
        checkResetStateA();
        rstA_n = 1'b1;
        releaseEdgeA = cycle;
        pushExpect(1'b0, 21, 1, 0, 1, 1, 32'h0, GOOD_TS, 4'd0, 1'b0);
        waitDone(1'b0, "A.midReset");

        @(negedge clock);
        rstB_n = 1'b1;
        releaseEdgeB = cycle;
        pushExpect(1'b1, 25, 1, 0, 1, 1, B_ID, GOOD_TS, 4'd0, 1'b0);
        waitDone(1'b1, "B.latency2");
        checkOutput("B.idReadCycles", 32'(idReadCyclesB), 32'd3);
        checkOutput("B.tsReadCycles", 32'(tsReadCyclesB), 32'd3);

        repeat (3) @(negedge clock);
        checkOutput("A.queueEmpty", 32'(expQA.size()), 32'd0);
        checkOutput("B.queueEmpty", 32'(expQB.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
